bpf_alu_sequencer: RTL and testbench
====================================

# bpf_alu_sequencer

Instruction sequencer that drives the BPF VM ALU: it fetches 64-bit BPF instructions from instruction memory, decodes them, presents operands and `ALU_sel` to the ALU, and consumes `ALU_out` and the predicate flags (`eq`, `gt`, `ge`, `set`). It owns the A and X registers and the PC, and executes a program to a RET. It sits between the packet-filter control logic (start/done) and the ALU plus instruction RAM.

## Interface
- `PC_WIDTH`, 10: instruction address width. Program length is at most 2^PC_WIDTH.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse that starts execution at PC 0. Ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at program end.
- `ret_val` out 32: RET value. Valid with `done` and held until the next `start`.
- `err` out 1: set with `done` on an illegal instruction or PC overflow. Held until the next `start`.
- `inst_addr` out PC_WIDTH: instruction read address.
- `inst_rd_en` out 1: read strobe.
- `inst_rd_data` in 64: {opcode[63:48], jt[47:40], jf[39:32], k[31:0]}. Valid exactly 1 cycle after `inst_rd_en`.
- `alu_a` out 32: A operand to the ALU.
- `alu_b` out 32: B operand to the ALU.
- `alu_sel` out 4: ALU operation select.
- `alu_out` in 32: ALU result.
- `eq`, `gt`, `ge`, `set` in 1 each: ALU predicate flags.

## Operation
- **FSM states:** IDLE, FETCH, DECODE, EXEC, ALUWAIT (macro only), HALT.
  - IDLE → FETCH on `start`. This clears A, X, PC, `err` and `ret_val`.
  - FETCH: drive `inst_rd_en`=1 and `inst_addr`=PC.
  - DECODE: latch `inst_rd_data` into IR.
  - EXEC: commit the instruction, then go to FETCH or HALT.
  - HALT: pulse `done` for 1 cycle, then go to IDLE.
- **Supported instruction classes** (opcode[2:0]):
  - LD (0), LDX (1): IMM mode only (opcode[7:5]=000). A or X ← k.
  - ALU (4): `alu_sel`=opcode[7:4]. `alu_a`=A. `alu_b`=X if opcode[3] else k. A ← `alu_out`.
  - JMP (5): op = opcode[7:4].
    - JA (0): PC ← PC+1+k.
    - JEQ (1), JGT (2), JGE (3), JSET (4): compare A against B (k or X). PC ← PC+1+(flag ? jt : jf).
  - RET (6): opcode[4:3]=00 returns k; =10 returns A. Go to HALT.
  - MISC (7): opcode[7:3]=00000 is TAX (X←A); 10000 is TXA (A←X).
  - Non-jump instructions: PC ← PC+1.
- **Illegal instructions:** any other class or mode, plus ALU ops MUL (2), DIV (3) and MOD (9) and any op above 0xA. Result: `err`=1, `ret_val`=0, go to HALT.
- **PC arithmetic:** next PC is computed at 33 bits. A value ≥ 2^PC_WIDTH gives `err`=1, `ret_val`=0, HALT. This also covers falling off the end of the program; the PC never wraps.
- **Idle outputs:** `alu_sel`, `alu_a` and `alu_b` are driven from IR and registers in EXEC/ALUWAIT and are 0 otherwise.

## Timing
- **Reset:** asynchronous, effective immediately.
  - State → IDLE.
  - Outputs `busy`, `done`, `err`, `inst_rd_en`, `inst_addr`, `ret_val`, `alu_a`, `alu_b`, `alu_sel` all go to 0.
  - A, X, PC → 0.
  - Reset mid-program abandons the program and produces no `done`.
- **Cycles per instruction:** 3 (FETCH, DECODE, EXEC). ALU and JMP instructions take 4 with the macro.
- **`done` latency:** `done` asserts the cycle after the EXEC of the RET or faulting instruction.
- **Start/done overlap:** `start` arriving in the same cycle as `done` is ignored. `start` is accepted in IDLE only.

## Configuration
- **`BPF_ALU_PESSIMISTIC_EN`:**
  - Defined: the ALU is assumed registered. ALU and JMP instructions pass through ALUWAIT for 1 cycle with operands and `alu_sel` held. Result and flags are sampled at the end of ALUWAIT.
  - Undefined: result and flags are sampled combinationally in EXEC, and ALUWAIT does not exist.

## Structure
- **Shared package `bpf_defs_pkg`:** class codes, ALU op codes, JMP op codes, RET source codes, the MISC TAX/TXA codes, the FSM state encoding, and the instruction field bit positions.
- **Sub-module `bpf_decode`:** purely combinational. Maps opcode to {class, alu_sel, src_is_x, jmp_op, ret_src, is_illegal}.

## Test plan
- LD #5; ADD #3 (0x04); RET A (0x16) → `ret_val`=8, `err`=0. `done` arrives 10 cycles after `start` (11 with the macro).
- LDX #4; LD #1; LSH X (0x6C); RET A → `ret_val`=16.
- LD #7; JEQ #7 jt=1 jf=0 (0x15); RET #0; RET #0xFFFF → 0xFFFF. Rerun with LD #6 → 0.
- DIV #2 (0x34) at PC 1 → `err`=1, `ret_val`=0, `done` pulses once, `busy` falls.
- PC_WIDTH=4; JA k=100 (0x05) at PC 0 → `err`=1. A second run: 16 ADDs with no RET → `err`=1 on overflow of PC 15.
- Assert `rst` during EXEC of program 1 → all outputs 0 immediately and no `done`. A following `start` → `ret_val`=8.

Source files
------------

// File: rtl/bpf_defs_pkg.sv
// Shared definitions for the BPF ALU sequencer: opcode fields, class/op codes,
// FSM state encoding and the decoded-instruction record.
package bpf_defs_pkg;

  // Instruction word layout: {opcode, jt, jf, k}
  localparam int OPC_HI = 63;
  localparam int OPC_LO = 48;
  localparam int JT_HI  = 47;
  localparam int JT_LO  = 40;
  localparam int JF_HI  = 39;
  localparam int JF_LO  = 32;
  localparam int K_HI   = 31;
  localparam int K_LO   = 0;

  localparam logic [2:0] CLS_LD   = 3'd0;
  localparam logic [2:0] CLS_LDX  = 3'd1;
  localparam logic [2:0] CLS_ALU  = 3'd4;
  localparam logic [2:0] CLS_JMP  = 3'd5;
  localparam logic [2:0] CLS_RET  = 3'd6;
  localparam logic [2:0] CLS_MISC = 3'd7;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_MUL = 4'h2;
  localparam logic [3:0] ALU_DIV = 4'h3;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_AND = 4'h5;
  localparam logic [3:0] ALU_LSH = 4'h6;
  localparam logic [3:0] ALU_RSH = 4'h7;
  localparam logic [3:0] ALU_NEG = 4'h8;
  localparam logic [3:0] ALU_MOD = 4'h9;
  localparam logic [3:0] ALU_XOR = 4'hA;

  localparam logic [3:0] JMP_JA   = 4'h0;
  localparam logic [3:0] JMP_JEQ  = 4'h1;
  localparam logic [3:0] JMP_JGT  = 4'h2;
  localparam logic [3:0] JMP_JGE  = 4'h3;
  localparam logic [3:0] JMP_JSET = 4'h4;

  localparam logic [1:0] RET_K = 2'b00;
  localparam logic [1:0] RET_A = 2'b10;

  localparam logic [4:0] MISC_TAX = 5'b00000;
  localparam logic [4:0] MISC_TXA = 5'b10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_ALUWAIT,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] cls;
    logic [3:0] alu_sel;
    logic       src_is_x;
    logic [3:0] jmp_op;
    logic [1:0] ret_src;
    logic       is_illegal;
  } dec_t;

endpackage

// File: rtl/bpf_alu_sequencer_if.sv
// Instruction-memory and ALU bus seen by the BPF ALU sequencer.
interface bpf_alu_sequencer_if #(
  parameter int PC_WIDTH = 10
);
  logic [PC_WIDTH-1:0] inst_addr;
  logic                inst_rd_en;
  logic [63:0]         inst_rd_data;
  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic [3:0]          alu_sel;
  logic [31:0]         alu_out;
  logic                eq;
  logic                gt;
  logic                ge;
  logic                set;

  modport master (
    output inst_addr, inst_rd_en, alu_a, alu_b, alu_sel,
    input  inst_rd_data, alu_out, eq, gt, ge, set
  );

  modport slave (
    input  inst_addr, inst_rd_en, alu_a, alu_b, alu_sel,
    output inst_rd_data, alu_out, eq, gt, ge, set
  );
endinterface

// File: rtl/bpf_decode.sv
// Combinational opcode decoder: class, ALU select, operand source, jump op,
// RET source and legality. A non-zero upper opcode byte is treated as illegal.
module bpf_decode
  import bpf_defs_pkg::*;
(
  input  logic [15:0] opcode,
  output dec_t        dec
);
  always_comb begin
    dec            = '0;
    dec.cls        = opcode[2:0];
    dec.src_is_x   = opcode[3];
    dec.jmp_op     = opcode[7:4];
    dec.ret_src    = opcode[4:3];
    case (opcode[2:0])
      CLS_LD, CLS_LDX: dec.is_illegal = (opcode[7:5] != 3'b000);
      CLS_ALU: begin
        dec.alu_sel    = opcode[7:4];
        dec.is_illegal = (opcode[7:4] == ALU_MUL) || (opcode[7:4] == ALU_DIV) ||
                         (opcode[7:4] == ALU_MOD) || (opcode[7:4] > ALU_XOR);
      end
      CLS_JMP:  dec.is_illegal = (opcode[7:4] > JMP_JSET);
      CLS_RET:  dec.is_illegal = (opcode[4:3] != RET_K) && (opcode[4:3] != RET_A);
      CLS_MISC: dec.is_illegal = (opcode[7:3] != MISC_TAX) && (opcode[7:3] != MISC_TXA);
      default:  dec.is_illegal = 1'b1;
    endcase
    dec.is_illegal = dec.is_illegal | (opcode[15:8] != 8'h00);
  end
endmodule

// File: rtl/bpf_alu_sequencer.sv
// Fetch/decode/execute sequencer driving the BPF VM ALU; owns A, X and PC.
// Define BPF_ALU_PESSIMISTIC_EN for a registered ALU (ALU/JMP pass through ALUWAIT).
module bpf_alu_sequencer
  import bpf_defs_pkg::*;
#(
  parameter int PC_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         ret_val,
  bpf_alu_sequencer_if.master bus
);
  state_t              state_reg, state_next;
  logic [31:0]         a_reg, a_next, x_reg, x_next, ret_reg, ret_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic                err_reg, err_next;
  logic [63:0]         ir_reg;
  logic [7:0]          ir_jt, ir_jf;
  logic [31:0]         ir_k, operand_b;
  logic                commit, flag;
  logic [32:0]         pc_wide;
  dec_t                dec;

  assign ir_jt = ir_reg[JT_HI:JT_LO];
  assign ir_jf = ir_reg[JF_HI:JF_LO];
  assign ir_k  = ir_reg[K_HI:K_LO];

  bpf_decode u_decode (
    .opcode (ir_reg[OPC_HI:OPC_LO]),
    .dec    (dec)
  );

  assign operand_b = dec.src_is_x ? x_reg : ir_k;

`ifdef BPF_ALU_PESSIMISTIC_EN
  logic needs_wait;
  assign needs_wait = !dec.is_illegal && (dec.cls == CLS_ALU || dec.cls == CLS_JMP);
  assign commit     = (state_reg == ST_EXEC && !needs_wait) || (state_reg == ST_ALUWAIT);
`else
  assign commit     = (state_reg == ST_EXEC);
`endif

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    x_next     = x_reg;
    pc_next    = pc_reg;
    err_next   = err_reg;
    ret_next   = ret_reg;
    pc_wide    = {{(33-PC_WIDTH){1'b0}}, pc_reg} + 33'd1;
    case (dec.jmp_op)
      JMP_JEQ:  flag = bus.eq;
      JMP_JGT:  flag = bus.gt;
      JMP_JGE:  flag = bus.ge;
      JMP_JSET: flag = bus.set;
      default:  flag = 1'b0;
    endcase
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          a_next     = '0;
          x_next     = '0;
          pc_next    = '0;
          err_next   = 1'b0;
          ret_next   = '0;
        end
      end
      ST_FETCH:   state_next = ST_DECODE;
      ST_DECODE:  state_next = ST_EXEC;
      ST_EXEC:    state_next = ST_ALUWAIT;
      ST_ALUWAIT: state_next = ST_FETCH;
      ST_HALT:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (commit) begin
      state_next = ST_FETCH;
      case (dec.cls)
        CLS_LD:  a_next = ir_k;
        CLS_LDX: x_next = ir_k;
        CLS_ALU: a_next = bus.alu_out;
        CLS_JMP: begin
          if (dec.jmp_op == JMP_JA) pc_wide = pc_wide + {1'b0, ir_k};
          else                      pc_wide = pc_wide + {25'd0, flag ? ir_jt : ir_jf};
        end
        CLS_RET: begin
          ret_next   = (dec.ret_src == RET_A) ? a_reg : ir_k;
          state_next = ST_HALT;
        end
        CLS_MISC: begin
          if (ir_reg[OPC_LO+7:OPC_LO+3] == MISC_TXA) a_next = x_reg;
          else                                       x_next = a_reg;
        end
        default: ;
      endcase
      // Next PC is checked at full width so running off the end faults instead of wrapping.
      if (dec.is_illegal || (dec.cls != CLS_RET && pc_wide[32:PC_WIDTH] != '0)) begin
        err_next   = 1'b1;
        ret_next   = '0;
        a_next     = a_reg;
        x_next     = x_reg;
        state_next = ST_HALT;
      end else if (dec.cls != CLS_RET) begin
        pc_next = pc_wide[PC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      x_reg     <= '0;
      pc_reg    <= '0;
      err_reg   <= 1'b0;
      ret_reg   <= '0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      x_reg     <= x_next;
      pc_reg    <= pc_next;
      err_reg   <= err_next;
      ret_reg   <= ret_next;
      if (state_reg == ST_DECODE) ir_reg <= bus.inst_rd_data;
    end
  end

  assign busy           = (state_reg == ST_FETCH) || (state_reg == ST_DECODE) ||
                          (state_reg == ST_EXEC)  || (state_reg == ST_ALUWAIT);
  assign done           = (state_reg == ST_HALT);
  assign err            = err_reg;
  assign ret_val        = ret_reg;
  assign bus.inst_rd_en = (state_reg == ST_FETCH);
  assign bus.inst_addr  = bus.inst_rd_en ? pc_reg : '0;

  always_comb begin
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_sel = '0;
    if (state_reg == ST_EXEC || state_reg == ST_ALUWAIT) begin
      bus.alu_a   = a_reg;
      bus.alu_b   = operand_b;
      bus.alu_sel = dec.alu_sel;
    end
  end
endmodule

// File: tb/tb_bpf_alu_sequencer.sv
// Bench for bpf_alu_sequencer: ISA-level model builds a per-cycle expected trace
// that a single negedge compare process checks; literal results pin the model.
module tb_bpf_alu_sequencer;
  localparam int PW    = 4;
  localparam int DEPTH = 1 << PW;
`ifdef BPF_ALU_PESSIMISTIC_EN
  localparam int P1_DONE = 11;
  localparam bit WAIT_EN = 1'b1;
`else
  localparam int P1_DONE = 10;
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct {
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [PW-1:0] addr;
    int            mode;  // 0: ALU outputs zero, 1: don't care, 2: check a/b, 3: check a/b/sel
    logic [3:0]    sel;
    logic [31:0]   a;
    logic [31:0]   b;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [31:0] ret_val;
  logic [63:0] mem [DEPTH];
  cyc_t        exp_q[$];
  cyc_t        cur;
  int          tests = 0;
  int          fails = 0;
  int          cyc_idx = 0;
  int          done_at = 0;
  bit          armed = 1'b0;

  bpf_alu_sequencer_if #(.PC_WIDTH(PW)) bus ();

  bpf_alu_sequencer #(.PC_WIDTH(PW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .ret_val (ret_val),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h4: return a | b;
      4'h5: return a & b;
      4'h6: return a << b;
      4'h7: return a >> b;
      4'h8: return -a;
      4'hA: return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) if (bus.inst_rd_en) bus.inst_rd_data <= mem[bus.inst_addr];

  always_comb begin
    bus.alu_out = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
    bus.eq      = (bus.alu_a == bus.alu_b);
    bus.gt      = (bus.alu_a > bus.alu_b);
    bus.ge      = (bus.alu_a >= bus.alu_b);
    bus.set     = ((bus.alu_a & bus.alu_b) != 32'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc_idx);
    end
  endtask

  function automatic cyc_t rec(input logic bz, input logic dn, input logic rd, input logic [PW-1:0] ad,
                               input int md, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    cyc_t r;
    r.busy = bz; r.done = dn; r.rd_en = rd; r.addr = ad;
    r.mode = md; r.sel = s; r.a = a; r.b = b;
    return r;
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] op, input logic [7:0] jt, input logic [7:0] jf, input logic [31:0] k);
    return {op, jt, jf, k};
  endfunction

  // Interpret the program at ISA level and emit the expected cycle sequence.
  task automatic build_model(output logic [31:0] m_ret, output logic m_err);
    longint      pc, npc;
    logic [31:0] A, X, k, b;
    logic [15:0] op;
    logic [7:0]  jt, jf;
    logic [63:0] ins;
    logic        bad, halt, f;
    int          md, steps;
    pc = 0; A = 0; X = 0; halt = 0; steps = 0; m_ret = 0; m_err = 0;
    exp_q.delete();
    while (!halt && steps < 64) begin
      ins = mem[pc[PW-1:0]];
      op = ins[63:48]; jt = ins[47:40]; jf = ins[39:32]; k = ins[31:0];
      b = op[3] ? X : k;
      exp_q.push_back(rec(1, 0, 1, pc[PW-1:0], 0, 0, 0, 0));
      exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0));
      bad = (op[15:8] != 0);
      md = 1;
      case (op[2:0])
        3'd0, 3'd1: bad |= (op[7:5] != 0);
        3'd4: begin bad |= (op[7:4] inside {4'h2, 4'h3, 4'h9}) || (op[7:4] > 4'hA); md = 3; end
        3'd5: begin bad |= (op[7:4] > 4'h4); md = 2; end
        3'd6: bad |= !(op[4:3] inside {2'b00, 2'b10});
        3'd7: bad |= !(op[7:3] inside {5'h00, 5'h10});
        default: bad = 1;
      endcase
      if (bad) md = 1;
      exp_q.push_back(rec(1, 0, 0, 0, md, op[7:4], A, b));
      if (WAIT_EN && !bad && (op[2:0] == 3'd4 || op[2:0] == 3'd5))
        exp_q.push_back(rec(1, 0, 0, 0, md, op[7:4], A, b));
      npc = pc + 1;
      if (bad) begin
        m_err = 1; m_ret = 0; halt = 1;
      end else begin
        case (op[2:0])
          3'd0: A = k;
          3'd1: X = k;
          3'd4: A = alu_f(op[7:4], A, b);
          3'd5: begin
            if (op[7:4] == 0) npc = pc + 1 + longint'(k);
            else begin
              case (op[7:4])
                4'h1:    f = (A == b);
                4'h2:    f = (A > b);
                4'h3:    f = (A >= b);
                default: f = ((A & b) != 0);
              endcase
              npc = pc + 1 + longint'(f ? jt : jf);
            end
          end
          3'd6: begin m_ret = op[4] ? A : k; halt = 1; end
          default: if (op[7]) A = X; else X = A;
        endcase
        if (!halt) begin
          if (npc >= DEPTH) begin m_err = 1; m_ret = 0; halt = 1; end
          else pc = npc;
        end
      end
      steps++;
    end
    exp_q.push_back(rec(0, 1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(rec(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (exp_q.size() == 0) armed = 1'b0;
      else begin
        cur = exp_q.pop_front();
        cyc_idx++;
        chk("busy", {31'd0, busy}, {31'd0, cur.busy});
        chk("done", {31'd0, done}, {31'd0, cur.done});
        chk("inst_rd_en", {31'd0, bus.inst_rd_en}, {31'd0, cur.rd_en});
        chk("inst_addr", {28'd0, bus.inst_addr}, {28'd0, cur.addr});
        if (done && done_at == 0) done_at = cyc_idx;
        if (cur.mode == 0) begin
          chk("alu_a_idle", bus.alu_a, 0);
          chk("alu_b_idle", bus.alu_b, 0);
          chk("alu_sel_idle", {28'd0, bus.alu_sel}, 0);
        end else if (cur.mode >= 2) begin
          chk("alu_a", bus.alu_a, cur.a);
          chk("alu_b", bus.alu_b, cur.b);
          if (cur.mode == 3) chk("alu_sel", {28'd0, bus.alu_sel}, {28'd0, cur.sel});
        end
        if (exp_q.size() == 0) armed = 1'b0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'h0;
  endtask

  task automatic run(input string name, input logic [31:0] lit_ret, input logic lit_err,
                     input int lit_done, input int poke);
    logic [31:0] m_ret;
    logic        m_err;
    int          n;
    build_model(m_ret, m_err);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc_idx = 0; done_at = 0; armed = 1'b1; n = 0;
    while (armed && n < 500) begin
      @(negedge clk);
      n++;
      start = (n == poke);
    end
    start = 1'b0;
    if (armed) begin
      tests++; fails++; armed = 1'b0;
      $display("FAIL %s timeout: got no end of trace, expected it within 500 cycles", name);
    end
    chk({name, "_ret_model"}, ret_val, m_ret);
    chk({name, "_err_model"}, {31'd0, err}, {31'd0, m_err});
    chk({name, "_ret_lit"}, ret_val, lit_ret);
    chk({name, "_err_lit"}, {31'd0, err}, {31'd0, lit_err});
    if (lit_done > 0) chk({name, "_done_latency"}, done_at, lit_done);
    $display("[TB] %s: ret_val=0x%08h err=%0d done_at=%0d", name, ret_val, err, done_at);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
    chk({tag, "_ret_val"}, ret_val, 0);
    chk({tag, "_rd_en"}, {31'd0, bus.inst_rd_en}, 0);
    chk({tag, "_addr"}, {28'd0, bus.inst_addr}, 0);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_alu_sel"}, {28'd0, bus.alu_sel}, 0);
  endtask

  task automatic load_p1();
    clear_mem();
    mem[0] = mk(16'h0000, 0, 0, 5);
    mem[1] = mk(16'h0004, 0, 0, 3);
    mem[2] = mk(16'h0016, 0, 0, 0);
  endtask

  initial begin
    int n_done;
    clear_mem();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    load_p1();
    run("ld_add_ret", 32'd8, 1'b0, P1_DONE, P1_DONE);

    clear_mem();
    mem[0] = mk(16'h0001, 0, 0, 4);
    mem[1] = mk(16'h0000, 0, 0, 1);
    mem[2] = mk(16'h006C, 0, 0, 0);
    mem[3] = mk(16'h0016, 0, 0, 0);
    run("lsh_x", 32'd16, 1'b0, 0, 5);

    clear_mem();
    mem[0] = mk(16'h0000, 0, 0, 7);
    mem[1] = mk(16'h0015, 1, 0, 7);
    mem[2] = mk(16'h0006, 0, 0, 0);
    mem[3] = mk(16'h0006, 0, 0, 32'hFFFF);
    run("jeq_taken", 32'hFFFF, 1'b0, 0, 0);
    mem[0] = mk(16'h0000, 0, 0, 6);
    run("jeq_not_taken", 32'h0, 1'b0, 0, 0);

    clear_mem();
    mem[0] = mk(16'h0000, 0, 0, 1);
    mem[1] = mk(16'h0034, 0, 0, 2);
    run("div_illegal", 32'h0, 1'b1, 0, 0);

    clear_mem();
    mem[0] = mk(16'h0005, 0, 0, 100);
    run("ja_overflow", 32'h0, 1'b1, 0, 0);

    clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = mk(16'h0004, 0, 0, 1);
    run("pc_runoff", 32'h0, 1'b1, 0, 0);

    clear_mem();
    mem[0] = mk(16'h0000, 0, 0, 9);
    mem[1] = mk(16'h0007, 0, 0, 0);
    mem[2] = mk(16'h0000, 0, 0, 0);
    mem[3] = mk(16'h0087, 0, 0, 0);
    mem[4] = mk(16'h0016, 0, 0, 0);
    run("tax_txa", 32'd9, 1'b0, 0, 0);

    clear_mem();
    mem[0] = mk(16'h0001, 0, 0, 3);
    mem[1] = mk(16'h0000, 0, 0, 5);
    mem[2] = mk(16'h002D, 0, 1, 0);
    mem[3] = mk(16'h0006, 0, 0, 1);
    mem[4] = mk(16'h0006, 0, 0, 2);
    run("jgt_x", 32'd1, 1'b0, 0, 0);

    // Abort program 1 in the EXEC cycle of its ADD.
    load_p1();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    chk("pre_rst_alu_b", bus.alu_b, 3);
    #1 rst = 1'b1;
    #1 check_zero("async_rst");
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("no_done_after_rst", n_done, 0);
    $display("[TB] async reset mid-program: done pulses after reset=%0d", n_done);
    run("after_reset", 32'd8, 1'b0, P1_DONE, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
